keyexpansion: RTL

- Iterative AES-128 key schedule that sits directly upstream of the add-round-key stage.
- Latches a 128-bit cipher key and streams round keys 0..NR in order over a valid/ready handshake.
- Output uses the same 4x4 byte-array layout the add-round-key stage consumes.
- Computes one 32-bit word per cycle using four shared S-box lookups, trading latency for area.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_sbox.sv | 43 ++++
 rtl/keyexpansion.sv | 106 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and helpers for the cipher datapath.
// Byte k of the FIPS-197 byte string sits at [k%4][k/4] (row, column).
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [3:0] word_t;
  typedef byte_t [3:0][3:0] state_t;

  localparam int NR_AES128 = 10;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    EXPAND
  } fsm_t;

  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: GF(2^8) inverse then affine map.
// Shared by the key schedule and the SubBytes stage.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t a,
  output byte_t s
);

  byte_t p;
  byte_t r;
  byte_t inv;

  function automatic byte_t gmul(byte_t x, byte_t y);
    byte_t acc;
    byte_t sh;
    acc = '0;
    sh  = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as required
  always_comb begin
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    inv = r;
    s = inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  end

endmodule

// File: rtl/keyexpansion.sv
// Iterative AES-128 key schedule: one word per cycle, four shared S-boxes,
// round keys 0..NR streamed over a valid/ready handshake.
module keyexpansion
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  state_t     key_in,
  output logic       busy,
  output logic       rk_valid,
  input  logic       rk_ready,
  output logic [3:0] rk_round,
  output state_t     roundkey,
  output logic       done
);

  fsm_t       st;
  fsm_t       st_nxt;
  state_t     w;
  byte_t      rcon;
  logic [1:0] wcnt;
  logic       load;
  logic       hs;
  logic       last;
  word_t      sin;
  word_t      sout;
  word_t      cur;
  word_t      prv;
  word_t      nw;

  assign hs       = rk_valid & rk_ready;
  assign last     = rk_round == 4'(NR);
  assign roundkey = w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  // a start in the done cycle is dropped even though st is already IDLE
  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:    if (start && !done) st_nxt = PRESENT;
      PRESENT: if (rk_ready) st_nxt = last ? IDLE : EXPAND;
      EXPAND:  if (wcnt == 2'd3) st_nxt = PRESENT;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = st != IDLE;
    rk_valid = st == PRESENT;
    load     = (st == IDLE) && start && !done;
  end

  // RotWord of column 3 feeds the S-boxes
  for (genvar g = 0; g < 4; g++) begin : g_sb
    assign sin[g] = w[(g + 1) % 4][3];
    aes_sbox u_sbox (
      .a (sin[g]),
      .s (sout[g])
    );
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      cur[r] = w[r][wcnt];
      prv[r] = w[r][wcnt - 2'd1];
      if (wcnt == 2'd0)
        nw[r] = cur[r] ^ sout[r] ^ ((r == 0) ? rcon : 8'h00);
      else
        nw[r] = cur[r] ^ prv[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w        <= '0;
      rcon     <= 8'h01;
      rk_round <= '0;
      wcnt     <= '0;
      done     <= 1'b0;
    end else begin
      done <= hs && last;
      if (load) begin
        w        <= key_in;
        rcon     <= 8'h01;
        rk_round <= '0;
      end
      if (hs) wcnt <= '0;
      if (st == EXPAND) begin
        wcnt <= wcnt + 2'd1;
        for (int r = 0; r < 4; r++) w[r][wcnt] <= nw[r];
        if (wcnt == 2'd3) begin
          rk_round <= rk_round + 4'd1;
          rcon     <= xtime(rcon);
        end
      end
    end
  end

endmodule
